// File: rtl/hazard_sequencer_if.sv
// ----------------------------------------------------------------------------
// hazard_sequencer_if
//   Bundles every signal that passes between the pipeline datapath and the
//   hazard/stall controller. The controller connects through the slave
//   modport. The datapath, or a testbench driving it, uses the master modport.
//
//   Datapath -> controller:
//     rs1D, rs2D      source registers of the instruction in D
//     rs1E, rs2E      source registers of the instruction in E
//     rdE, regwriteE  destination and write-enable of E
//     wbselE          E writeback select, 2'b00 = load data
//     rdM, regwriteM  destination and write-enable of M
//     rdW, regwriteW  destination and write-enable of W
//     pcsrcE          branch taken or jump resolved in E
//     mc_reqE         E holds a multi-cycle op
//     mc_done         multi-cycle unit result valid (1-cycle pulse)
//
//   Controller -> datapath:
//     fwdAE, fwdBE    operand select: 00 regfile, 01 W result, 10 M ALU result
//     stallF/D/E      hold PC, IF/ID and ID/EX
//     flushD/E/M      bubble IF/ID, ID/EX and EX/MEM
//     mc_start        start pulse to the multi-cycle unit
//     mc_timeout      watchdog abort pulse
//     stall_cnt       saturating count of cycles with stallD=1
//     flush_cnt       saturating count of cycles with flushD=1
//
//   CNT_W must match the CNT_W of the connected hazard_sequencer.
// ----------------------------------------------------------------------------
interface hazard_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rs1E;
    logic [4:0]       rs2E;
    logic [4:0]       rdE;
    logic             regwriteE;
    logic [1:0]       wbselE;
    logic [4:0]       rdM;
    logic             regwriteM;
    logic [4:0]       rdW;
    logic             regwriteW;
    logic             pcsrcE;
    logic             mc_reqE;
    logic             mc_done;

    logic [1:0]       fwdAE;
    logic [1:0]       fwdBE;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             flushD;
    logic             flushE;
    logic             flushM;
    logic             mc_start;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, regwriteE, wbselE,
               rdM, regwriteM, rdW, regwriteW, pcsrcE, mc_reqE, mc_done,
        output fwdAE, fwdBE, stallF, stallD, stallE, flushD, flushE, flushM,
               mc_start, mc_timeout, stall_cnt, flush_cnt
    );

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, regwriteE, wbselE,
               rdM, regwriteM, rdW, regwriteW, pcsrcE, mc_reqE, mc_done,
        input  fwdAE, fwdBE, stallF, stallD, stallE, flushD, flushE, flushM,
               mc_start, mc_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sequencer.sv
// ----------------------------------------------------------------------------
// hazard_sequencer
//   Hazard and stall controller for a 5-stage F/D/E/M/W pipeline.
//   - Selects forwarding sources for both execute-stage operands. M has
//     priority over W, and x0 is never forwarded.
//   - Inserts a single bubble for a load-use hazard.
//   - Flushes D and E on a branch or jump redirect resolved in E.
//   - Sequences multi-cycle execute ops (mul/div) using a start/done
//     handshake. A watchdog aborts the op after TIMEOUT cycles in BUSY.
//   - Keeps saturating performance counters for stall and flush cycles.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset. While it is high, every output is 0.
//   hz   hazard_sequencer_if.slave (see the interface file for the signals)
//
// Parameters:
//   TIMEOUT  maximum number of cycles spent in BUSY before the watchdog
//            aborts the op. Must be at least 2.
//   CNT_W    width of the performance counters
// ----------------------------------------------------------------------------
module hazard_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_sequencer_if.slave hz
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    timer_q;
    logic             mc_timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_d;

    // ------------------------------------------------------------------
    // Forwarding: operand 0 is rs1E and operand 1 is rs2E.
    // ------------------------------------------------------------------
    logic [1:0][4:0] src_e;
    logic [1:0][1:0] fwd_sel;

    assign src_e[0] = hz.rs1E;
    assign src_e[1] = hz.rs2E;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic hit_m;
        logic hit_w;
        assign hit_m = hz.regwriteM && (hz.rdM != 5'd0) && (hz.rdM == src_e[gi]);
        assign hit_w = hz.regwriteW && (hz.rdW != 5'd0) && (hz.rdW == src_e[gi]);
        assign fwd_sel[gi] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
    end

    // ------------------------------------------------------------------
    // Stall / flush control
    // ------------------------------------------------------------------
    logic lwstall;
    logic mc_busy;
    logic mc_last;     // final BUSY cycle: the result arrives or the watchdog fires
    logic watchdog;
    logic stall_f, stall_d, stall_e;
    logic flush_d, flush_e, flush_m;
    logic start;

    assign lwstall = hz.regwriteE && (hz.wbselE == 2'b00) && (hz.rdE != 5'd0) &&
                     ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
    assign mc_busy  = (state_q == BUSY);
    assign watchdog = mc_busy && !hz.mc_done && (timer_q == TIMER_LAST);
    assign mc_last  = mc_busy && (hz.mc_done || (timer_q == TIMER_LAST));

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        start   = 1'b0;
        if (!mc_busy) begin
            // A multi-cycle op in E takes precedence. E cannot also hold the
            // redirecting branch, so pcsrcE is not acted on in that cycle.
            if (hz.mc_reqE) begin
                start   = 1'b1;
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (hz.pcsrcE) begin
                // A redirect beats a load-use stall so that the new PC is fetched.
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lwstall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end else if (!mc_last) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (lwstall) begin
            // On the release cycle E advances normally, so a load-use hazard
            // behaves as it would in IDLE. pcsrcE is still ignored here.
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Saturating counter next-state values
    assign stall_cnt_d = (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) ?
                         stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign flush_cnt_d = (flush_d && (flush_cnt_q != {CNT_W{1'b1}})) ?
                         flush_cnt_q + CNT_W'(1) : flush_cnt_q;

    // ------------------------------------------------------------------
    // Multi-cycle FSM, watchdog timer and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            mc_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            mc_timeout_q <= watchdog;
            case (state_q)
                IDLE: begin
                    if (hz.mc_reqE) begin
                        state_q <= BUSY;
                        timer_q <= '0;
                    end
                end
                BUSY: begin
                    if (mc_last) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The combinational outputs are gated by rst so that they read
    // as 0 for the whole time reset is held, not only after the next edge.
    // ------------------------------------------------------------------
    assign hz.fwdAE      = rst ? 2'b00 : fwd_sel[0];
    assign hz.fwdBE      = rst ? 2'b00 : fwd_sel[1];
    assign hz.stallF     = !rst && stall_f;
    assign hz.stallD     = !rst && stall_d;
    assign hz.stallE     = !rst && stall_e;
    assign hz.flushD     = !rst && flush_d;
    assign hz.flushE     = !rst && flush_e && !stall_e;   // a hold wins over a bubble
    assign hz.flushM     = !rst && flush_m;
    assign hz.mc_start   = !rst && start;
    assign hz.mc_timeout = mc_timeout_q;
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_sequencer.sv
// ----------------------------------------------------------------------------
// tb_hazard_sequencer
//   Self-checking bench for hazard_sequencer (TIMEOUT=8, CNT_W=4). The small
//   counter width lets the bench exercise saturation quickly.
//
//   Every stimulated cycle is compared against a cycle-level reference
//   model. The model tracks only whether a multi-cycle op is in flight, the
//   cycle it started, a pending watchdog pulse and the two counter values as
//   integers.
//
//   The bench applies a table of single-cycle vectors, a set of hand-written
//   multi-cycle sequences and a randomized run.
// ----------------------------------------------------------------------------
module tb_hazard_sequencer;
    localparam int TO   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
        logic       regwriteE;
        logic [1:0] wbselE;
        logic [4:0] rdM;
        logic       regwriteM;
        logic [4:0] rdW;
        logic       regwriteW;
        logic       pcsrcE, mc_reqE, mc_done;
    } in_t;

    typedef struct packed {
        logic [1:0]    fwdA, fwdB;
        logic          stallF, stallD, stallE, flushD, flushE, flushM;
        logic          mc_start, mc_timeout;
        logic [CW-1:0] stall_cnt, flush_cnt;
    } out_t;

    typedef struct {
        string      name;
        in_t        i;
        logic [10:0] exp;   // {fwdA, fwdB, stallF, stallD, stallE, flushD, flushE, flushM, mc_start}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_sequencer_if #(.CNT_W(CW)) hif();

    hazard_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit m_busy;
    int m_start_cyc;
    bit m_tmo;
    int m_stall;
    int m_flush;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        hif.rs1D      = i.rs1D;
        hif.rs2D      = i.rs2D;
        hif.rs1E      = i.rs1E;
        hif.rs2E      = i.rs2E;
        hif.rdE       = i.rdE;
        hif.regwriteE = i.regwriteE;
        hif.wbselE    = i.wbselE;
        hif.rdM       = i.rdM;
        hif.regwriteM = i.regwriteM;
        hif.rdW       = i.rdW;
        hif.regwriteW = i.regwriteW;
        hif.pcsrcE    = i.pcsrcE;
        hif.mc_reqE   = i.mc_reqE;
        hif.mc_done   = i.mc_done;
    endtask

    function automatic out_t get_out();
        out_t o;
        o.fwdA       = hif.fwdAE;
        o.fwdB       = hif.fwdBE;
        o.stallF     = hif.stallF;
        o.stallD     = hif.stallD;
        o.stallE     = hif.stallE;
        o.flushD     = hif.flushD;
        o.flushE     = hif.flushE;
        o.flushM     = hif.flushM;
        o.mc_start   = hif.mc_start;
        o.mc_timeout = hif.mc_timeout;
        o.stall_cnt  = hif.stall_cnt;
        o.flush_cnt  = hif.flush_cnt;
        return o;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t i);
        if (i.regwriteM && i.rdM != 0 && i.rdM == rs) return 2'b10;
        if (i.regwriteW && i.rdW != 0 && i.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Number of whole BUSY cycles already spent before the current one
    function automatic int elapsed();
        return cyc - m_start_cyc - 1;
    endfunction

    function automatic bit ref_last(input in_t i);
        return m_busy && (i.mc_done || elapsed() == TO - 1);
    endfunction

    function automatic out_t ref_out(input in_t i);
        out_t o;
        bit   lw;
        o  = '0;
        lw = i.regwriteE && i.wbselE == 2'b00 && i.rdE != 0 &&
             (i.rdE == i.rs1D || i.rdE == i.rs2D);
        o.fwdA = ref_fwd(i.rs1E, i);
        o.fwdB = ref_fwd(i.rs2E, i);
        if (m_busy && !ref_last(i)) begin
            {o.stallF, o.stallD, o.stallE, o.flushM} = 4'b1111;
        end else if (!m_busy && i.mc_reqE) begin
            {o.stallF, o.stallD, o.stallE, o.flushM, o.mc_start} = 5'b11111;
        end else if (!m_busy && i.pcsrcE) begin
            {o.flushD, o.flushE} = 2'b11;
        end else if (lw) begin
            {o.stallF, o.stallD, o.flushE} = 3'b111;
        end
        o.mc_timeout = m_tmo;
        o.stall_cnt  = CW'(m_stall);
        o.flush_cnt  = CW'(m_flush);
        return o;
    endfunction

    task automatic ref_step(input in_t i, input out_t o);
        bit last;
        last    = ref_last(i);
        m_tmo   = m_busy && !i.mc_done && elapsed() == TO - 1;
        m_stall = (o.stallD && m_stall < CMAX) ? m_stall + 1 : m_stall;
        m_flush = (o.flushD && m_flush < CMAX) ? m_flush + 1 : m_flush;
        if (!m_busy && i.mc_reqE) begin
            m_busy      = 1'b1;
            m_start_cyc = cyc;
        end else if (last) begin
            m_busy = 1'b0;
        end
        cyc++;
    endtask

    task automatic ref_reset();
        m_busy  = 1'b0;
        m_tmo   = 1'b0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // One clock cycle: drive the inputs, compare against the model, advance.
    task automatic cycle(input in_t i, input string nm, output out_t act);
        out_t exp;
        @(negedge clk);
        drive(i);
        #1;
        act = get_out();
        exp = ref_out(i);
        $display("t=%0t %s in=%h out=%h exp=%h", $time, nm, i, act, exp);
        chk({nm, " model"}, 64'(act), 64'(exp));
        @(posedge clk);
        ref_step(i, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive('0);
        #1;
        chk("reset outputs", 64'(get_out()), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_reset();
    endtask

    vec_t tbl[11];
    in_t  v;
    out_t a;
    int   nstall;

    initial begin
        drive('0);

        // ---------------- table of single-cycle vectors (IDLE) ----------------
        foreach (tbl[k]) tbl[k].i = '0;
        tbl[0].name = "fwdA from M";
        tbl[0].i.rdM = 5; tbl[0].i.regwriteM = 1; tbl[0].i.rdW = 5; tbl[0].i.regwriteW = 1; tbl[0].i.rs1E = 5;
        tbl[0].exp = 11'b10_00_0000000;
        tbl[1].name = "fwdA from W";
        tbl[1].i.rdM = 5; tbl[1].i.rdW = 5; tbl[1].i.regwriteW = 1; tbl[1].i.rs1E = 5;
        tbl[1].exp = 11'b01_00_0000000;
        tbl[2].name = "x0 not forwarded";
        tbl[2].i.regwriteM = 1; tbl[2].i.regwriteW = 1;
        tbl[2].exp = 11'b00_00_0000000;
        tbl[3].name = "fwdB from W";
        tbl[3].i.rs2E = 7; tbl[3].i.rdW = 7; tbl[3].i.regwriteW = 1; tbl[3].i.rdM = 6; tbl[3].i.regwriteM = 1;
        tbl[3].exp = 11'b00_01_0000000;
        tbl[4].name = "both from M";
        tbl[4].i.rs1E = 9; tbl[4].i.rs2E = 9; tbl[4].i.rdM = 9; tbl[4].i.regwriteM = 1; tbl[4].i.rdW = 9; tbl[4].i.regwriteW = 1;
        tbl[4].exp = 11'b10_10_0000000;
        tbl[5].name = "load-use";
        tbl[5].i.regwriteE = 1; tbl[5].i.rdE = 3; tbl[5].i.rs2D = 3;
        tbl[5].exp = 11'b00_00_1100100;
        tbl[6].name = "non-load no stall";
        tbl[6].i.regwriteE = 1; tbl[6].i.wbselE = 2'b01; tbl[6].i.rdE = 3; tbl[6].i.rs2D = 3;
        tbl[6].exp = 11'b00_00_0000000;
        tbl[7].name = "load to x0";
        tbl[7].i.regwriteE = 1; tbl[7].i.rdE = 0;
        tbl[7].exp = 11'b00_00_0000000;
        tbl[8].name = "redirect over lw";
        tbl[8].i.regwriteE = 1; tbl[8].i.rdE = 4; tbl[8].i.rs1D = 4; tbl[8].i.pcsrcE = 1;
        tbl[8].exp = 11'b00_00_0001100;
        tbl[9].name = "redirect";
        tbl[9].i.pcsrcE = 1;
        tbl[9].exp = 11'b00_00_0001100;
        tbl[10].name = "done in IDLE";
        tbl[10].i.mc_done = 1;
        tbl[10].exp = 11'b00_00_0000000;

        do_reset();
        foreach (tbl[k]) begin
            cycle(tbl[k].i, tbl[k].name, a);
            chk({tbl[k].name, " vec"},
                64'({a.fwdA, a.fwdB, a.stallF, a.stallD, a.stallE, a.flushD, a.flushE, a.flushM, a.mc_start}),
                64'(tbl[k].exp));
        end

        // ---------------- load-use: exactly one bubble ----------------
        do_reset();
        v = '0; v.regwriteE = 1; v.rdE = 3; v.rs2D = 3;
        cycle(v, "lw hazard", a);
        chk("lw stall", 64'({a.stallF, a.stallD, a.flushE}), 64'(3'b111));
        v = '0; v.rs2D = 3;                        // E now holds the bubble
        cycle(v, "lw bubble", a);
        chk("lw released", 64'({a.stallF, a.stallD, a.flushE}), 64'(0));
        chk("lw stall_cnt", 64'(a.stall_cnt), 64'(1));

        // ---------------- redirect beats load-use ----------------
        do_reset();
        v = '0; v.regwriteE = 1; v.rdE = 3; v.rs1D = 3; v.pcsrcE = 1;
        cycle(v, "redir+lw", a);
        chk("redir flush", 64'({a.flushD, a.flushE, a.stallF, a.stallD}), 64'(4'b1100));
        cycle('0, "after redir", a);
        chk("redir flush_cnt", 64'(a.flush_cnt), 64'(1));
        chk("redir stall_cnt", 64'(a.stall_cnt), 64'(0));

        // ---------------- mc op with mc_done ----------------
        do_reset();
        v = '0; v.mc_reqE = 1;
        cycle(v, "mc start", a);
        chk("mc_start", 64'({a.mc_start, a.stallE, a.flushM}), 64'(3'b111));
        for (int k = 0; k < 5; k++) begin
            cycle(v, "mc busy", a);
            chk("mc busy hold", 64'({a.mc_start, a.stallF, a.stallD, a.stallE, a.flushM}), 64'(5'b01111));
        end
        v.mc_done = 1; v.pcsrcE = 1;                // pcsrcE ignored in BUSY
        cycle(v, "mc done", a);
        chk("mc release", 64'({a.stallF, a.stallD, a.stallE, a.flushM, a.flushD, a.mc_start}), 64'(0));
        cycle('0, "mc after", a);
        chk("mc stall_cnt", 64'(a.stall_cnt), 64'(6));
        chk("mc no timeout", 64'(a.mc_timeout), 64'(0));

        // ---------------- watchdog timeout ----------------
        do_reset();
        v = '0; v.mc_reqE = 1;
        nstall = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(v, "wd run", a);
            if (!a.stallD) break;
            nstall++;
        end
        chk("wd stall cycles", 64'(nstall), 64'(TO));
        chk("wd no pulse yet", 64'(a.mc_timeout), 64'(0));
        cycle('0, "wd pulse", a);
        chk("wd pulse", 64'({a.mc_timeout, a.mc_start}), 64'(2'b10));
        v = '0; v.mc_reqE = 1;
        cycle(v, "wd idle again", a);
        chk("wd pulse ends/idle", 64'({a.mc_timeout, a.mc_start}), 64'(2'b01));
        cycle(v, "wd busy2", a);

        // ---------------- asynchronous reset in BUSY ----------------
        do_reset();
        v = '0; v.mc_reqE = 1;
        for (int k = 0; k < 3; k++) cycle(v, "rstbusy pre", a);
        @(negedge clk);
        drive(v);
        #1;
        chk("rstbusy stalled", 64'(hif.stallF), 64'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("rstbusy async zero", 64'(get_out()), 64'(0));
        drive('0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_reset();
        cycle('0, "rstbusy release", a);
        chk("rstbusy no start", 64'({a.mc_start, a.stallD}), 64'(0));
        chk("rstbusy counters", 64'({a.stall_cnt, a.flush_cnt}), 64'(0));
        cycle(v, "rstbusy req", a);
        chk("rstbusy start", 64'(a.mc_start), 64'(1));

        // ---------------- counter saturation ----------------
        do_reset();
        v = '0; v.regwriteE = 1; v.rdE = 2; v.rs1D = 2;
        for (int k = 0; k < CMAX + 4; k++) cycle(v, "sat", a);
        chk("stall_cnt saturated", 64'(a.stall_cnt), 64'(CMAX));

        // ---------------- randomized run ----------------
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) do_reset();
            v.rs1D      = 5'($urandom_range(0, 3));
            v.rs2D      = 5'($urandom_range(0, 3));
            v.rs1E      = 5'($urandom_range(0, 3));
            v.rs2E      = 5'($urandom_range(0, 3));
            v.rdE       = 5'($urandom_range(0, 3));
            v.rdM       = 5'($urandom_range(0, 3));
            v.rdW       = 5'($urandom_range(0, 3));
            v.regwriteE = 1'($urandom_range(0, 1));
            v.regwriteM = 1'($urandom_range(0, 1));
            v.regwriteW = 1'($urandom_range(0, 1));
            v.wbselE    = 2'($urandom_range(0, 3));
            v.pcsrcE    = ($urandom_range(0, 5) == 0);
            v.mc_reqE   = ($urandom_range(0, 4) == 0);
            v.mc_done   = ($urandom_range(0, 5) == 0);
            cycle(v, "rand", a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
